chrono_display: RTL and testbench

CHRONO_DISPLAY -- requirements
Module: chrono_display

---
 rtl/chrono_display.sv | 110 +++++++++++
 tb/tb_chrono_display.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chrono_display.sv
// chrono_display: four-digit multiplexed stopwatch display (ss.cc).
// A slot counter walks the four digits; a snapshot of the BCD inputs is
// taken only at frame boundaries so every frame shows one coherent value.
// The last cycle of each slot is a blank guard cycle against ghosting.
module chrono_display #(
    parameter int SYSFREQ  = 50000000,
    parameter int SCANFREQ = 1000
) (
    input  logic       ck,
    input  logic       cl_n,
    input  logic [3:0] c0,
    input  logic [3:0] c1,
    input  logic [3:0] s0,
    input  logic [3:0] s1,
    input  logic       freeze,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    // Clock cycles per digit slot; must be at least 2.
    localparam int P     = SYSFREQ / SCANFREQ;
    localparam int DIV_W = $clog2(P);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(P - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_sel;
    logic [15:0]      r_snap;

    logic             w_last;
    logic             w_frame_end;
    logic [3:0]       w_nib;
    logic [6:0]       w_glyph;
    logic             w_blank;

    assign w_last      = (r_div == DIV_LAST);
    assign w_frame_end = w_last && (r_sel == 2'd3);

    // Slot timing: div counts 0..P-1, sel advances on the last cycle of a slot.
    always_ff @(posedge ck) begin
        // NOTE: non-blocking assignments keep every register update based on
        // pre-edge values, so the order of statements here does not matter.
        if (!cl_n) begin
            r_div <= '0;
            r_sel <= 2'd0;
        end else if (w_last) begin
            r_div <= '0;
            r_sel <= r_sel + 2'd1;
        end else begin
            r_div <= r_div + DIV_ONE;
        end
    end

    // Snapshot: captured only at the frame boundary and only while not frozen.
    always_ff @(posedge ck) begin
        if (!cl_n) begin
            r_snap <= 16'h0000;
        end else if (w_frame_end && !freeze) begin
            r_snap <= {s1, s0, c1, c0};
        end
    end

    // Pick the snapshot nibble belonging to the active digit.
    always_comb begin
        // NOTE: a default before the case means every path assigns w_nib,
        // so no latch is inferred even if the case is later edited.
        w_nib = r_snap[3:0];
        case (r_sel)
            2'd0:    w_nib = r_snap[3:0];
            2'd1:    w_nib = r_snap[7:4];
            2'd2:    w_nib = r_snap[11:8];
            default: w_nib = r_snap[15:12];
        endcase
    end

    // BCD to active-low seven-segment {g,f,e,d,c,b,a}; non-BCD shows a dash.
    always_comb begin
        w_glyph = 7'b0111111;
        case (w_nib)
            4'd0:    w_glyph = 7'b1000000;
            4'd1:    w_glyph = 7'b1111001;
            4'd2:    w_glyph = 7'b0100100;
            4'd3:    w_glyph = 7'b0110000;
            4'd4:    w_glyph = 7'b0011001;
            4'd5:    w_glyph = 7'b0010010;
            4'd6:    w_glyph = 7'b0000010;
            4'd7:    w_glyph = 7'b1111000;
            4'd8:    w_glyph = 7'b0000000;
            4'd9:    w_glyph = 7'b0010000;
            default: w_glyph = 7'b0111111;
        endcase
    end

    // Leading zero on the seconds-tens digit is blanked.
    assign w_blank = (r_sel == 2'd3) && (r_snap[15:12] == 4'd0);

    // Drive the display; everything goes dark during the guard cycle.
    always_comb begin
        an  = 4'b1111;
        seg = 7'b1111111;
        dp  = 1'b1;
        if (!w_last) begin
            an  = ~(4'b0001 << r_sel);
            seg = w_blank ? 7'b1111111 : w_glyph;
            dp  = (r_sel != 2'd2);
        end
    end

endmodule

// File: tb/tb_chrono_display.sv
// Self-checking bench for chrono_display with P = 4 cycles per slot.
// The reference model tracks only the cycle count since reset and the value
// shown in the current frame; expected outputs come from that arithmetic.
module tb_chrono_display;

    localparam int SYSFREQ  = 1000;
    localparam int SCANFREQ = 250;
    localparam int P        = SYSFREQ / SCANFREQ;
    localparam int FRAME    = 4 * P;

    logic       ck;
    logic       cl_n;
    logic [3:0] c0, c1, s0, s1;
    logic       freeze;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int total = 0;
    int bad   = 0;

    // Reference model state: cycles since reset release, value on display.
    int          m_cnt  = 0;
    logic [15:0] m_snap = 16'h0000;

    logic [6:0] glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };

    chrono_display #(
        .SYSFREQ (SYSFREQ),
        .SCANFREQ(SCANFREQ)
    ) dut (
        .ck    (ck),
        .cl_n  (cl_n),
        .c0    (c0),
        .c1    (c1),
        .s0    (s0),
        .s1    (s1),
        .freeze(freeze),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Expected {an, seg, dp} for the model's current cycle.
    function automatic logic [11:0] model_out();
        int         d;
        int         s;
        logic [3:0] nib;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        d = m_cnt % P;
        s = (m_cnt / P) % 4;
        if (d == P - 1) return {4'b1111, 7'b1111111, 1'b1};
        nib   = m_snap[4*s +: 4];
        e_an  = 4'b1111;
        e_an[s] = 1'b0;
        e_seg = (s == 3 && nib == 4'd0) ? 7'b1111111 : glyph[nib];
        e_dp  = (s == 2) ? 1'b0 : 1'b1;
        return {e_an, e_seg, e_dp};
    endfunction

    function automatic logic [15:0] rand_bcd();
        return {4'($urandom_range(9)), 4'($urandom_range(9)),
                4'($urandom_range(9)), 4'($urandom_range(9))};
    endfunction

    task automatic set_in(input logic [15:0] v);
        {s1, s0, c1, c0} = v;
    endtask

    // Advance one clock; the model sees the same inputs the DUT samples.
    task automatic tick();
        if (!cl_n) begin
            m_cnt  = 0;
            m_snap = 16'h0000;
        end else begin
            if ((m_cnt % FRAME) == FRAME - 1 && !freeze) m_snap = {s1, s0, c1, c0};
            m_cnt++;
        end
        @(posedge ck);
        #1;
    endtask

    task automatic do_reset();
        cl_n = 1'b0;
        tick();
        cl_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [11:0] e;
        cl_n   = 1'b0;
        freeze = 1'b1;
        set_in(16'($urandom));
        tick();
        tick();
        total++;
        if ({an, seg, dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
            bad++;
            $display("FAIL reset_outputs got an=%b seg=%b dp=%b want an=1110 seg=1000000 dp=1", an, seg, dp);
        end
        cl_n   = 1'b1;
        freeze = 1'b0;
        set_in(16'h1234);
        repeat (FRAME) begin
            tick();
            e = model_out();
            total++;
            if ({an, seg, dp} !== e) begin
                bad++;
                $display("FAIL reset_first_frames cnt=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         m_cnt, an, seg, dp, e[11:8], e[7:1], e[0]);
            end
        end
    endtask

    task automatic test_basic();
        logic [3:0] l_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] l_seg [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        logic       l_dp  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [11:0] e;
        int k;
        do_reset();
        set_in(16'h1234);
        repeat (FRAME - 1) begin
            tick();
            e = model_out();
            total++;
            if ({an, seg, dp} !== e) begin
                bad++;
                $display("FAIL basic_frame1 cnt=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         m_cnt, an, seg, dp, e[11:8], e[7:1], e[0]);
            end
        end
        repeat (FRAME) begin
            tick();
            k = m_cnt - FRAME;
            if (k % P == P - 1) e = {4'b1111, 7'b1111111, 1'b1};
            else                e = {l_an[k/P], l_seg[k/P], l_dp[k/P]};
            total++;
            if ({an, seg, dp} !== e) begin
                bad++;
                $display("FAIL basic_1234 cnt=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         m_cnt, an, seg, dp, e[11:8], e[7:1], e[0]);
            end
        end
    endtask

    task automatic test_blank_dp();
        logic [6:0] l_seg [4] = '{7'b0010000, 7'b0010010, 7'b1111000, 7'b1111111};
        logic       l_dp  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [11:0] e;
        int k;
        do_reset();
        set_in(16'h0759);
        repeat (FRAME - 1) tick();
        repeat (FRAME) begin
            tick();
            k = m_cnt - FRAME;
            if (k % P == P - 1) e = {4'b1111, 7'b1111111, 1'b1};
            else                e = {~(4'b0001 << (k / P)), l_seg[k/P], l_dp[k/P]};
            total++;
            if ({an, seg, dp} !== e) begin
                bad++;
                $display("FAIL blank_dp_0759 cnt=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         m_cnt, an, seg, dp, e[11:8], e[7:1], e[0]);
            end
        end
    endtask

    task automatic test_midframe();
        logic [15:0] va;
        logic [15:0] vb;
        logic [11:0] e;
        va = rand_bcd();
        va[15:12] = 4'($urandom_range(9, 1));
        for (int i = 0; i < 4; i++) vb[4*i +: 4] = 4'((va[4*i +: 4] + 4'd3) % 10);
        do_reset();
        set_in(va);
        while (m_cnt < FRAME + P) tick();
        set_in(vb);
        while (m_cnt < 3 * FRAME) begin
            tick();
            e = model_out();
            total++;
            if ({an, seg, dp} !== e) begin
                bad++;
                $display("FAIL midframe cnt=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         m_cnt, an, seg, dp, e[11:8], e[7:1], e[0]);
            end
            if (m_cnt == FRAME + 2 * P || m_cnt == 2 * FRAME + 2 * P) begin
                total++;
                if (seg !== glyph[(m_cnt < 2 * FRAME) ? va[11:8] : vb[11:8]]) begin
                    bad++;
                    $display("FAIL midframe_s0 cnt=%0d got seg=%b want seg=%b", m_cnt, seg,
                             glyph[(m_cnt < 2 * FRAME) ? va[11:8] : vb[11:8]]);
                end
            end
        end
    endtask

    task automatic test_freeze();
        logic [6:0]  ref_seg [FRAME];
        logic [15:0] v2;
        logic [11:0] e;
        do_reset();
        set_in(rand_bcd());
        while (m_cnt < FRAME + P) tick();
        freeze = 1'b1;
        while (m_cnt < 5 * FRAME) begin
            set_in(16'($urandom));
            tick();
            if (m_cnt >= 2 * FRAME && m_cnt < 3 * FRAME) ref_seg[m_cnt % FRAME] = seg;
            if (m_cnt >= 3 * FRAME) begin
                total++;
                if (seg !== ref_seg[m_cnt % FRAME]) begin
                    bad++;
                    $display("FAIL freeze_hold cnt=%0d got seg=%b want seg=%b", m_cnt, seg, ref_seg[m_cnt % FRAME]);
                end
            end
            e = model_out();
            total++;
            if ({an, seg, dp} !== e) begin
                bad++;
                $display("FAIL freeze_model cnt=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         m_cnt, an, seg, dp, e[11:8], e[7:1], e[0]);
            end
        end
        freeze = 1'b0;
        v2 = rand_bcd();
        set_in(v2);
        while (m_cnt < 6 * FRAME + 2 * P) tick();
        total++;
        if (seg !== glyph[v2[11:8]] || dp !== 1'b0) begin
            bad++;
            $display("FAIL freeze_release got seg=%b dp=%b want seg=%b dp=0", seg, dp, glyph[v2[11:8]]);
        end
    endtask

    task automatic test_dash();
        logic [15:0] v;
        logic [11:0] e;
        v = rand_bcd();
        v[15:12] = 4'($urandom_range(9, 1));
        v[7:4]   = 4'hC;
        do_reset();
        set_in(v);
        while (m_cnt < 2 * FRAME - 1) begin
            tick();
            e = model_out();
            total++;
            if ({an, seg, dp} !== e) begin
                bad++;
                $display("FAIL dash_model cnt=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         m_cnt, an, seg, dp, e[11:8], e[7:1], e[0]);
            end
            if (m_cnt == FRAME + P) begin
                total++;
                if ({an, seg} !== {4'b1101, 7'b0111111}) begin
                    bad++;
                    $display("FAIL dash_c1 got an=%b seg=%b want an=1101 seg=0111111", an, seg);
                end
            end
            if (m_cnt == FRAME + 3 * P) begin
                total++;
                if (seg !== glyph[v[15:12]]) begin
                    bad++;
                    $display("FAIL dash_s1 got seg=%b want seg=%b", seg, glyph[v[15:12]]);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] v;
        logic [11:0] e;
        v = rand_bcd();
        v[15:12] = 4'($urandom_range(9, 1));
        v[3:0]   = 4'($urandom_range(9, 1));
        do_reset();
        set_in(v);
        while (m_cnt < FRAME + 2 * P + 1) tick();
        freeze = 1'b1;
        cl_n   = 1'b0;
        tick();
        cl_n   = 1'b1;
        total++;
        if ({an, seg, dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
            bad++;
            $display("FAIL reset_midframe got an=%b seg=%b dp=%b want an=1110 seg=1000000 dp=1", an, seg, dp);
        end
        repeat (FRAME + P) begin
            tick();
            e = model_out();
            total++;
            if ({an, seg, dp} !== e) begin
                bad++;
                $display("FAIL reset_midframe_after cnt=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         m_cnt, an, seg, dp, e[11:8], e[7:1], e[0]);
            end
        end
        freeze = 1'b0;
    endtask

    task automatic test_random();
        logic [11:0] e;
        do_reset();
        repeat (1200) begin
            cl_n = ($urandom_range(199) != 0);
            if ($urandom_range(29) == 0) freeze = ~freeze;
            if ($urandom_range(2) == 0) set_in(16'($urandom));
            tick();
            cl_n = 1'b1;
            e = model_out();
            total++;
            if ({an, seg, dp} !== e) begin
                bad++;
                $display("FAIL random cnt=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         m_cnt, an, seg, dp, e[11:8], e[7:1], e[0]);
            end
        end
    endtask

    initial begin
        cl_n   = 1'b0;
        freeze = 1'b0;
        set_in(16'h0000);
        test_reset();
        test_basic();
        test_blank_dp();
        test_midframe();
        test_freeze();
        test_dash();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
